manhattan_dist_gen: RTL

Sequential producer of the eight 10-bit distances d_0..d_7 that the team's 8-way min/argmin selector consumes. A start pulse latches a query point. The block then accepts 8 reference points over a valid/ready stream and computes the Manhattan distance |x-qx|+|y-qy| for each. It presents the full distance vector with a valid/ack handshake.

---
 rtl/manhattan_dist_gen_pkg.sv | 21 ++
 rtl/manhattan_dist_gen_if.sv | 37 +++
 rtl/manhattan_dist_gen_abs_diff.sv | 17 +
 rtl/manhattan_dist_gen.sv | 108 ++++++++++
 4 files changed

// File: rtl/manhattan_dist_gen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | manhattan_dist_gen_pkg : shared widths, point count, FSM codes |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`ifndef MANHATTAN_DIST_GEN_DEFS
`define MANHATTAN_DIST_GEN_DEFS
`define D_DataSize 10
`endif

package manhattan_dist_gen_pkg;

  localparam int N_PTS       = 8;
  localparam int COORD_W_DEF = 9;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/manhattan_dist_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | manhattan_dist_gen_if : query/point stream and distance vector |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface manhattan_dist_gen_if
  import manhattan_dist_gen_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int D_W     = `D_DataSize
);

  logic               start;
  logic [COORD_W-1:0] q_x;
  logic [COORD_W-1:0] q_y;
  logic               pt_valid;
  logic               pt_ready;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic [D_W-1:0]     d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7;
  logic               dist_valid;
  logic               dist_ack;
  logic               busy;

  // master supplies the query and points, slave is the distance generator
  modport master (
    output start, q_x, q_y, pt_valid, pt_x, pt_y, dist_ack,
    input  pt_ready, d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7, dist_valid, busy
  );

  modport slave (
    input  start, q_x, q_y, pt_valid, pt_x, pt_y, dist_ack,
    output pt_ready, d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7, dist_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/manhattan_dist_gen_abs_diff.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | abs_diff : unsigned |a-b| without sign extension               |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module abs_diff #(
  parameter int W = 9
) (
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  output logic      [W-1:0] y
);

  assign y = (a >= b) ? (a - b) : (b - a);

endmodule
`default_nettype wire

// File: rtl/manhattan_dist_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | manhattan_dist_gen : 8 Manhattan distances to a latched query  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module manhattan_dist_gen
  import manhattan_dist_gen_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int D_W     = `D_DataSize
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  manhattan_dist_gen_if.slave bus
);

  if ((D_W != `D_DataSize) || (D_W < COORD_W + 1)) begin : g_width_check
    $error("manhattan_dist_gen: D_W must equal D_DataSize and be at least COORD_W+1");
  end

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [2:0]         r_cnt;
  logic [COORD_W-1:0] r_qx;
  logic [COORD_W-1:0] r_qy;
  logic [D_W-1:0]     r_d [N_PTS];
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic [D_W-1:0]     w_dist;
  logic               w_pt_ready;
  logic               w_dist_valid;
  logic               w_busy;
  logic               w_hs;

  abs_diff #(.W(COORD_W)) u_abs_x (.a(bus.pt_x), .b(r_qx), .y(w_dx));
  abs_diff #(.W(COORD_W)) u_abs_y (.a(bus.pt_y), .b(r_qy), .y(w_dy));

  // width guarantee above means this sum never wraps
  assign w_dist = D_W'(w_dx) + D_W'(w_dy);
  assign w_hs   = bus.pt_valid & w_pt_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start)                 w_next_state = ACCUM;
      ACCUM:   if (w_hs && (r_cnt == 3'd7))   w_next_state = DONE;
      DONE:    if (bus.dist_ack)              w_next_state = IDLE;
      default:                                w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_pt_ready   = 1'b0;
    w_dist_valid = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ACCUM: begin
        w_pt_ready = 1'b1;
        w_busy     = 1'b1;
      end
      DONE: begin
        w_dist_valid = 1'b1;
        w_busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // counter wraps 7->0 on the final handshake, so it is already clear for the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      r_qx  <= '0;
      r_qy  <= '0;
      for (int i = 0; i < N_PTS; i++) r_d[i] <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_cnt <= 3'd0;
      r_qx  <= bus.q_x;
      r_qy  <= bus.q_y;
      for (int i = 0; i < N_PTS; i++) r_d[i] <= '0;
    end else if (w_hs) begin
      r_d[r_cnt] <= w_dist;
      r_cnt      <= r_cnt + 3'd1;
    end
  end

  assign bus.pt_ready   = w_pt_ready;
  assign bus.dist_valid = w_dist_valid;
  assign bus.busy       = w_busy;
  assign bus.d_0        = r_d[0];
  assign bus.d_1        = r_d[1];
  assign bus.d_2        = r_d[2];
  assign bus.d_3        = r_d[3];
  assign bus.d_4        = r_d[4];
  assign bus.d_5        = r_d[5];
  assign bus.d_6        = r_d[6];
  assign bus.d_7        = r_d[7];

endmodule
`default_nettype wire
